// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit sync-pattern serial links.
// Contents:
//   link_state_t          frame state type, shared by transmitter and receiver
//   SYNC_W_DEFAULT        default sync pattern width
//   SYNC_PATTERN_DEFAULT  default sync pattern (sent MSB first)
//   max3                  elaboration-time helper for sizing counters
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } link_state_t;

    localparam int                        SYNC_W_DEFAULT       = 5;
    localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PATTERN_DEFAULT = 5'b11101;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-line bundle between the local controller and the transmitter.
// Signals:
//   start      controller -> tx  request to send a frame
//   data_in    controller -> tx  payload, captured when the request is accepted
//   ready      tx -> controller  transmitter idle, start will be accepted
//   dataout    tx -> line        serial bit, 0 outside frame bits
//   bit_valid  tx -> line        dataout carries a sync or payload bit
//   busy       tx -> controller  frame in progress
//   done       tx -> controller  one-cycle pulse in the final gap cycle
// Modports: master = controller side, slave = transmitter side.
interface serial_pattern_tx_if #(
    parameter int DATA_W = 8
) ();

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              dataout;
    logic              bit_valid;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  dataout,
        input  bit_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output dataout,
        output bit_valid,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_pattern_tx_piso_shift_reg.sv
// Parallel-in, serial-out shift register, MSB first.
// Ports:
//   clock   rising-edge clock
//   load    capture par_in (takes priority over shift)
//   shift   move contents one place toward the MSB, filling with 0
//   par_in  parallel load value
//   msb     current most significant bit (the next serial bit)
// Holds payload data only, so it carries no reset; the owner always loads
// it before any bit is used.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             msb
);

    logic [WIDTH-1:0] bits;

    always_ff @(posedge clock) begin
        if (load) begin
            bits <= par_in;
        end else if (shift) begin
            bits <= bits << 1;
        end
    end

    assign msb = bits[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: sync pattern, then DATA_W payload bits (both MSB
// first), then GAP_CYCLES idle cycles, with a start/ready/done handshake.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serial_pattern_tx_if slave: start, data_in in; ready, dataout,
//          bit_valid, busy, done out (all outputs registered)
// The payload is not bit-stuffed; the receiver frames by counting.
module serial_pattern_tx
    import serial_link_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int                GAP_CYCLES   = 2
) (
    input logic               clock,
    input logic               reset,
    serial_pattern_tx_if.slave bus
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    link_state_t      state;
    logic [CNT_W-1:0] cnt;        // index of the bit/cycle currently on the outputs
    logic             ready_r;
    logic             dataout_r;
    logic             bit_valid_r;
    logic             busy_r;
    logic             done_r;

    logic             payload_load;
    logic             payload_shift;
    logic             payload_msb;

    // Sync bit at position idx, counted from the MSB of the pattern.
    function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
        logic [SYNC_W-1:0] shifted;
        shifted = SYNC_PATTERN << idx;
        return shifted[SYNC_W-1];
    endfunction

    // The payload MSB is put on the line at the SYNC->DATA edge, so the
    // register advances on that edge and on every DATA edge except the last.
    assign payload_load  = !reset && (state == IDLE) && bus.start;
    assign payload_shift = !reset &&
                           (((state == SYNC) && (cnt == SYNC_LAST)) ||
                            ((state == DATA) && (cnt != DATA_LAST)));

    piso_shift_reg #(
        .WIDTH (DATA_W)
    ) payload (
        .clock  (clock),
        .load   (payload_load),
        .shift  (payload_shift),
        .par_in (bus.data_in),
        .msb    (payload_msb)
    );

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_r     <= 1'b1;
            dataout_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= SYNC;
                        cnt         <= '0;
                        ready_r     <= 1'b0;
                        dataout_r   <= sync_bit('0);
                        bit_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end

                SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state     <= DATA;
                        cnt       <= '0;
                        dataout_r <= payload_msb;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        dataout_r <= sync_bit(cnt + CNT_ONE);
                    end
                end

                DATA: begin
                    if (cnt == DATA_LAST) begin
                        state       <= GAP;
                        cnt         <= '0;
                        dataout_r   <= 1'b0;
                        bit_valid_r <= 1'b0;
                        done_r      <= (GAP_LAST == '0);
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                        dataout_r <= payload_msb;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        done_r <= ((cnt + CNT_ONE) == GAP_LAST);
                    end
                end

                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    ready_r     <= 1'b1;
                    dataout_r   <= 1'b0;
                    bit_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.dataout   = dataout_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a literal vector table for reset
// and a single A5 frame, directed multi-cycle sequences, randomized stimulus
// against a queue-based frame model, and a 16-bit/3-gap instance looped into
// a behavioural 11101 detector.
module tb_serial_pattern_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    serial_pattern_tx_if #(.DATA_W(8))  if0 ();
    serial_pattern_tx_if #(.DATA_W(16)) if1 ();

    serial_pattern_tx #(
        .DATA_W(8), .SYNC_W(5), .SYNC_PATTERN(5'b11101), .GAP_CYCLES(2)
    ) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    serial_pattern_tx #(
        .DATA_W(16), .SYNC_W(5), .SYNC_PATTERN(5'b11101), .GAP_CYCLES(3)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1.slave)
    );

    // Expected outputs for one cycle: {dataout, bit_valid, busy, done, ready}.
    typedef struct packed {
        logic dout;
        logic bv;
        logic busy;
        logic done;
        logic ready;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       st;
        logic [7:0] d;
        logic [4:0] exp;
    } vec_t;

    localparam outs_t IDLE_O = '{dout: 1'b0, bv: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    localparam logic [4:0] SYNC_P = 5'b11101;

    int checks = 0;
    int errors = 0;

    outs_t exp_cur = IDLE_O;
    outs_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.dout  = if0.dataout;
        o.bv    = if0.bit_valid;
        o.busy  = if0.busy;
        o.done  = if0.done;
        o.ready = if0.ready;
        return o;
    endfunction

    // Frame as a list of per-cycle outputs: sync bits, payload bits, gap.
    task automatic load_frame(input logic [7:0] d);
        exp_q.delete();
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{dout: SYNC_P[4-i], bv: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0});
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{dout: d[7-i], bv: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0});
        for (int g = 0; g < 2; g++)
            exp_q.push_back('{dout: 1'b0, bv: 1'b0, busy: 1'b1, done: (g == 1), ready: 1'b0});
    endtask

    // Drive inputs, cross one edge, advance the model, optionally compare.
    task automatic step(input logic r, input logic s, input logic [7:0] d, input bit chk);
        reset       = r;
        if0.start   = s;
        if0.data_in = d;
        @(posedge clock);
        #1;
        if (r) begin
            exp_q.delete();
            exp_cur = IDLE_O;
        end else if (exp_cur.ready && s) begin
            load_frame(d);
            exp_cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
        end else begin
            exp_cur = IDLE_O;
        end
        if (chk) check("model", int'(dut_outs()), int'(exp_cur));
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [7:0] d, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.st = s; v.d = d; v.exp = e;
        return v;
    endfunction

    initial begin
        int   rises;
        int   dones;
        int   second_rise;
        logic prev_busy;

        if0.start   = 1'b0;
        if0.data_in = '0;
        if1.start   = 1'b0;
        if1.data_in = '0;

        // Reset with start high, one idle cycle, then one A5 frame.
        vecs.push_back(mk(1, 1, 8'h5A, 5'b00001));
        vecs.push_back(mk(1, 1, 8'h5A, 5'b00001));
        vecs.push_back(mk(1, 1, 8'h5A, 5'b00001));
        vecs.push_back(mk(0, 0, 8'h5A, 5'b00001));
        vecs.push_back(mk(0, 1, 8'hA5, 5'b11100)); // cycle 1: sync 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // sync 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // sync 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b01100)); // sync 0
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // sync 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // A5 bit7 = 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b01100)); // 0
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b01100)); // 0
        vecs.push_back(mk(0, 0, 8'h00, 5'b01100)); // 0
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b01100)); // 0
        vecs.push_back(mk(0, 0, 8'h00, 5'b11100)); // cycle 13: 1
        vecs.push_back(mk(0, 0, 8'h00, 5'b00100)); // cycle 14: gap
        vecs.push_back(mk(0, 0, 8'h00, 5'b00110)); // cycle 15: gap + done
        vecs.push_back(mk(0, 0, 8'h00, 5'b00001)); // cycle 16: ready

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].d, 1'b0);
            check($sformatf("vec%0d", i), int'(dut_outs()), int'(vecs[i].exp));
        end

        // Back-to-back frames with start held: FF then 00.
        rises = 0; dones = 0; second_rise = -1; prev_busy = 1'b0;
        for (int k = 0; k < 31; k++) begin
            step(1'b0, 1'b1, (k == 0) ? 8'hFF : 8'h00, 1'b1);
            if (if0.busy && !prev_busy) begin
                rises++;
                if (rises == 2) second_rise = k + 1;
            end
            if (if0.done) dones++;
            prev_busy = if0.busy;
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("b2b_second_start_cycle", second_rise, 17);
        check("b2b_done_count", dones, 2);

        // Start during an active frame is ignored and not queued.
        rises = 0; prev_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, (k == 0) || (k == 7), (k == 0) ? 8'h3C : 8'hC3, 1'b1);
            if (if0.busy && !prev_busy) rises++;
            prev_busy = if0.busy;
        end
        check("ignored_start_frames", rises, 1);
        check("ignored_start_ready", int'(if0.ready), 1);

        // Reset in cycle 9 abandons the frame without a done pulse.
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            step(k == 9, k == 0, 8'h96, 1'b1);
            if (if0.done) dones++;
            if (k == 9) begin
                check("midreset_ready", int'(if0.ready), 1);
                check("midreset_busy", int'(if0.busy), 0);
                check("midreset_dout", int'(if0.dataout), 0);
            end
        end
        check("midreset_no_done", dones, 0);
        dones = 0;
        for (int k = 0; k < 17; k++) begin
            step(1'b0, k == 0, 8'h5B, 1'b1);
            if (if0.done) dones++;
        end
        check("post_reset_frame_done", dones, 1);

        // Randomized starts, payloads and occasional resets.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // 16-bit payload, 3-cycle gap, looped into an 11101 detector model.
        begin
            logic [4:0] hist;
            int         rise_q[$];
            int         det_q[$];
            int         done_q[$];
            int         n;
            hist = '0;
            prev_busy = 1'b0;
            for (int k = 0; k < 80; k++) begin
                reset       = 1'b0;
                if1.start   = (k < 60);
                if1.data_in = 16'h0000;
                @(posedge clock);
                #1;
                hist = {hist[3:0], if1.dataout};
                if (hist == 5'b11101) det_q.push_back(k);
                if (if1.busy && !prev_busy) rise_q.push_back(k);
                if (if1.done) done_q.push_back(k);
                prev_busy = if1.busy;
            end
            if1.start = 1'b0;
            check("loop_frames", rise_q.size(), 3);
            check("loop_detects", det_q.size(), 3);
            check("loop_dones", done_q.size(), 3);
            n = rise_q.size();
            if (det_q.size() < n) n = det_q.size();
            if (done_q.size() < n) n = done_q.size();
            for (int i = 0; i < n; i++) begin
                check($sformatf("loop_detect_align%0d", i), det_q[i] - rise_q[i], 4);
                check($sformatf("loop_frame_len%0d", i), done_q[i] - rise_q[i] + 1, 24);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
